aq_f_spsram_128x8_ctrl: RTL and testbench

Requester-side controller for the 128x8 single-port SRAM macro wrapper. It sits between a core-side valid/ready request port and the wrapper's `A/CEN/CLK/D/GWEN/WEN/Q` pins, and drives the macro protocol. After every reset it sweeps the whole array to `INIT_VAL`. During operation it buffers read data so the response consumer can apply backpressure without losing the macro's one-cycle `Q`.

---
 rtl/aq_f_spsram_128x8_ctrl.sv | 131 +++++++++++++
 tb/tb_aq_f_spsram_128x8_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aq_f_spsram_128x8_ctrl.sv
// Requester-side controller for the 128x8 single-port SRAM macro wrapper.
// Sweeps the array to INIT_VAL after every reset, then maps a valid/ready
// request port onto the macro pins and buffers read data in a 3-entry FIFO
// so the response consumer can stall without losing the macro's Q.
module aq_f_spsram_128x8_ctrl #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic                  mem_CEN,
  output logic                  mem_GWEN,
  output logic [DATA_WIDTH-1:0] mem_WEN,
  output logic [DATA_WIDTH-1:0] mem_D,
  input  logic [DATA_WIDTH-1:0] mem_Q
);

  typedef enum logic [1:0] {
    RST_IDLE = 2'd0,
    INIT     = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [3];
  logic [1:0]            wptr, rptr, fifo_cnt;
  logic [2:0]            occupancy;
  logic                  accept, push, pop;

  // Pointer advance with wrap at the third entry
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Outstanding reads = one in the macro pipeline plus those already buffered
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, rd_inflight};
  assign req_rdy   = init_done & (occupancy < 3'd3);
  assign accept    = req_vld & req_rdy;
  assign rsp_vld   = (fifo_cnt != 2'd0);
  assign rsp_rdata = fifo_mem[rptr];
  assign push      = rd_inflight;
  assign pop       = rsp_vld & rsp_rdy;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and macro pin drive
  always_comb begin
    state_nxt = state;
    mem_CEN   = 1'b1;
    mem_GWEN  = 1'b0;
    mem_WEN   = '0;
    mem_A     = '0;
    mem_D     = '0;
    case (state)
      RST_IDLE: state_nxt = INIT;
      INIT: begin
        mem_CEN  = 1'b0;
        mem_GWEN = 1'b1;
        mem_WEN  = '1;
        mem_A    = init_cnt;
        mem_D    = INIT_VAL;
        if (&init_cnt) state_nxt = RUN;
      end
      RUN: begin
        mem_CEN  = ~accept;
        mem_GWEN = req_wr;
        mem_A    = req_addr;
        mem_D    = req_wdata;
        mem_WEN  = req_wr ? req_wmask : '0;
      end
      default: state_nxt = RST_IDLE;
    endcase
  end

  // Sweep address counter and completion flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (&init_cnt) init_done <= 1'b1;
    end
  end

  // Marks the cycle in which the macro presents Q for an accepted read
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rd_inflight <= 1'b0;
    else     rd_inflight <= accept & ~req_wr;
  end

  // Response FIFO; storage is cleared on reset so rsp_rdata reads 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < 3; i++) fifo_mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= mem_Q;
        wptr           <= ptr_inc(wptr);
      end
      if (pop) rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_f_spsram_128x8_ctrl.sv
// Self-checking bench for aq_f_spsram_128x8_ctrl: a behavioural macro model
// answers the pins, and an expected-memory / expected-response-queue model
// built from the request port predicts every response.
module tb_aq_f_spsram_128x8_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req_vld = 1'b0, req_wr = 1'b0, rsp_rdy = 1'b1;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0, req_wmask = '0;
  logic       req_rdy, rsp_vld, init_done, mem_CEN, mem_GWEN;
  logic [7:0] rsp_rdata, mem_WEN, mem_D, mem_Q;
  logic [6:0] mem_A;

  int errors = 0, checks = 0, cyc = 0, nacc = 0, nrsp = 0;
  logic [7:0] last_rsp;
  logic [7:0] ref_mem [128];
  logic [7:0] macro [128];
  logic [7:0] exp_q [$];
  int         rsp_cyc [$];

  aq_f_spsram_128x8_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .INIT_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .mem_A(mem_A), .mem_CEN(mem_CEN), .mem_GWEN(mem_GWEN), .mem_WEN(mem_WEN),
    .mem_D(mem_D), .mem_Q(mem_Q)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Macro model: bit-masked write, or read with Q valid the following cycle
  always @(posedge CLK) begin
    if (!mem_CEN) begin
      if (mem_GWEN) macro[mem_A] <= (macro[mem_A] & ~mem_WEN) | (mem_D & mem_WEN);
      else          mem_Q <= macro[mem_A];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [6:0] a,
                       input logic [7:0] d, input logic [7:0] m);
    req_vld = v; req_wr = w; req_addr = a; req_wdata = d; req_wmask = m;
  endtask

  // Observe one cycle's handshakes against the model, then move to next negedge
  task automatic step();
    #1;
    if (req_vld && req_rdy) begin
      nacc++;
      if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
      else        exp_q.push_back(ref_mem[req_addr]);
    end
    if (rsp_vld) chk("rsp_pending", 32'(exp_q.size() != 0), 1);
    if (rsp_vld && rsp_rdy && exp_q.size() != 0) begin
      chk("rsp_data", rsp_rdata, exp_q[0]);
      last_rsp = rsp_rdata;
      void'(exp_q.pop_front());
      nrsp++;
      rsp_cyc.push_back(cyc);
    end
    @(negedge CLK);
  endtask

  task automatic idle_drain();
    drive(0, 0, 0, 0, 0);
    rsp_rdy = 1'b1;
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_rdy"}, req_rdy, 0);
    chk({tag, "_rsp_vld"}, rsp_vld, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_cen"}, mem_CEN, 1);
    chk({tag, "_gwen"}, mem_GWEN, 0);
    chk({tag, "_wen"}, mem_WEN, 0);
    chk({tag, "_a"}, mem_A, 0);
    chk({tag, "_d"}, mem_D, 0);
  endtask

  // Release reset at a negedge (before E0) and follow the 128-cycle sweep
  task automatic sweep();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    drive(1, 0, 7'($urandom), 0, 0);
    RST = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      @(negedge CLK); #1;
      chk("sweep_init_done_low", init_done, 0);
      chk("sweep_req_rdy_low", req_rdy, 0);
      chk("sweep_rsp_vld_low", rsp_vld, 0);
      chk("sweep_cen", mem_CEN, 0);
      chk("sweep_gwen", mem_GWEN, 1);
      chk("sweep_wen", mem_WEN, 8'hFF);
      chk("sweep_a", mem_A, 32'(k - 1));
      chk("sweep_d", mem_D, 8'h00);
      if (k == 128) drive(0, 0, 0, 0, 0);
    end
    @(negedge CLK); #1;
    chk("init_done_cycle129", init_done, 1);
    chk("req_rdy_cycle129", req_rdy, 1);
    @(negedge CLK);
  endtask

  initial begin
    logic [7:0] hold;
    int nrsp0;
    for (int i = 0; i < 128; i++) macro[i] = 8'($urandom);
    repeat (3) @(negedge CLK);
    #1 check_reset_vals("por");
    @(negedge CLK);

    // Sweep then read back the whole array
    sweep();
    rsp_rdy = 1'b1;
    nrsp = 0;
    for (int a = 0; a < 128; a++) begin drive(1, 0, 7'(a), 0, 0); step(); end
    idle_drain();
    chk("sweep_nrsp", nrsp, 128);

    // Masked write then read with latency check
    drive(1, 1, 7'h05, 8'hFF, 8'hFF); step();
    drive(1, 1, 7'h05, 8'h00, 8'h0F); step();
    drive(1, 0, 7'h05, 0, 0); #1 chk("mask_rd_rdy", req_rdy, 1); step();
    drive(0, 0, 0, 0, 0); #1 chk("mask_n1_vld", rsp_vld, 0); step();
    #1;
    chk("mask_n2_vld", rsp_vld, 1);
    chk("mask_n2_data", rsp_rdata, 8'hF0);
    step();

    // Streaming reads of preloaded data
    for (int i = 0; i < 10; i++) begin drive(1, 1, 7'(i), 8'(i) ^ 8'h5A, 8'hFF); step(); end
    rsp_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 7'(i), 0, 0);
      #1 chk("stream_rdy", req_rdy, 1);
      step();
    end
    idle_drain();
    chk("stream_n", rsp_cyc.size(), 10);
    if (rsp_cyc.size() == 10) chk("stream_consec", rsp_cyc[9] - rsp_cyc[0], 9);

    // Backpressure
    rsp_rdy = 1'b0;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin drive(1, 0, 7'($urandom), 0, 0); step(); end
    #1;
    chk("bp_nacc", nacc, 3);
    chk("bp_rdy_low", req_rdy, 0);
    chk("bp_vld", rsp_vld, 1);
    hold = rsp_rdata;
    for (int i = 0; i < 3; i++) step();
    #1 chk("bp_stable", rsp_rdata, hold);
    nrsp0 = nrsp;
    idle_drain();
    chk("bp_drained", nrsp - nrsp0, 3);
    #1 chk("bp_rdy_back", req_rdy, 1);
    @(negedge CLK);

    // Read-after-write at the top address
    drive(1, 1, 7'h7F, 8'h3C, 8'hFF); step();
    drive(1, 0, 7'h7F, 0, 0); step();
    idle_drain();
    chk("raw_data", last_rsp, 8'h3C);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rsp_rdy = 1'($urandom);
      drive(1'($urandom), 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
    idle_drain();

    // Known value at 0x7F, then reset with 2 buffered and 1 in flight
    drive(1, 1, 7'h7F, 8'hA5, 8'hFF); step();
    rsp_rdy = 1'b0;
    drive(1, 0, 7'h7F, 0, 0); step();
    drive(1, 0, 7'h05, 0, 0); step();
    drive(1, 0, 7'h07, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_rdy_low", req_rdy, 0);
    chk("pre_rst_vld", rsp_vld, 1);
    RST = 1'b1;
    #1 check_reset_vals("midrst");
    exp_q.delete();
    @(negedge CLK); @(negedge CLK);
    #1 check_reset_vals("midrst_hold");
    @(negedge CLK);
    sweep();
    rsp_rdy = 1'b1;
    nrsp0 = nrsp;
    drive(1, 0, 7'h7F, 0, 0); step();
    idle_drain();
    chk("post_rst_nrsp", nrsp - nrsp0, 1);
    chk("post_rst_data", last_rsp, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
